instr_fetch_unit: RTL

Fetch stage that produces the instruction stream consumed by the main controller and its decoders. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. Returned words go into a small FIFO, and the FIFO head is presented to decode over a valid/ready handshake, with the op/funct3/funct7 fields pre-split. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words over imem req/ack into a
// small FIFO and presents the head to decode with pre-split fields.
module instr_fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000,
    parameter int unsigned          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);
    localparam int unsigned     AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CW     = AW + 1;
    localparam logic [CW-1:0]   FULL   = CW'(DEPTH);
    localparam logic [0:0]      S_FETCH = 1'b0;
    localparam logic [0:0]      S_DROP  = 1'b1;
    localparam logic [XLEN-1:0] NOP    = XLEN'(32'h0000_0013);

    logic [0:0]      state;
    logic [0:0]      state_nx;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] addr_nx;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [XLEN-1:0] buf_pc [DEPTH];
    logic            fire;
    logic            push;
    logic            pop;
    logic            req_nx;

    assign fire        = imem_req && imem_ack;
    assign push        = fire && (state == S_FETCH) && !redirect;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        count_nx = count;
        if (redirect) begin
            pc_nx    = {redirect_pc[XLEN-1:2], 2'b00};
            count_nx = '0;
            // an unanswered request must be drained before the target is fetched
            if (imem_req && !imem_ack) begin
                state_nx = S_DROP;
            end else begin
                state_nx = S_FETCH;
            end
        end else begin
            if (fire) begin
                state_nx = S_FETCH;
            end
            if (push) begin
                pc_nx = pc + XLEN'(4);
            end
            unique case ({push, pop})
                2'b10:   count_nx = count + CW'(1);
                2'b01:   count_nx = count - CW'(1);
                default: count_nx = count;
            endcase
        end
        if (state_nx == S_DROP) begin
            req_nx  = 1'b1;
            addr_nx = imem_addr;
        end else begin
            req_nx  = (count_nx < FULL);
            addr_nx = pc_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            count     <= count_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= pc;
        end
    end

    assign instr    = instr_valid ? buf_data[rd_ptr] : NOP;
    assign instr_pc = instr_valid ? buf_pc[rd_ptr] : pc;
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

endmodule
